// File: rtl/byte_word_packer_if.sv
// Handshake bundle for byte_word_packer: byte-side valid/ready/flush and word-side valid/ready/bytes.
// Each lane c occupies slice [c*W +: W] of every vector.
interface byte_word_packer_if #(
    parameter int CHANNELS       = 2,
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int WORD_W         = BYTE_W * BYTES_PER_WORD,
    parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
);
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS*BYTE_W-1:0] in_data;
    logic [CHANNELS-1:0]        in_ready;
    logic [CHANNELS-1:0]        flush;
    logic [CHANNELS-1:0]        out_valid;
    logic [CHANNELS*WORD_W-1:0] out_data;
    logic [CHANNELS*CNT_W-1:0]  out_bytes;
    logic [CHANNELS-1:0]        out_ready;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bytes
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_bytes
    );
endinterface

// File: rtl/byte_word_packer.sv
// Multi-lane byte-to-word packer, first byte in the MSB lane, explicit fill count per lane.
// Define BYTE_WORD_PACKER_FLUSH_EN to enable emitting partial words on flush.
module byte_word_packer #(
    parameter int CHANNELS       = 2,
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int WORD_W         = BYTE_W * BYTES_PER_WORD,
    parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
    input logic               clk,
    input logic               rst_n,
    byte_word_packer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES_PER_WORD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WORD_W-1:0] acc, acc_ins, acc_nxt, word_q;
        logic [CNT_W-1:0]  cnt, cnt_nxt, bytes_q;
        logic [BYTE_W-1:0] din;
        logic              valid_q, flush_pend;
        logic              out_free, ready, accept, complete, flush_req, fire;

        assign din      = bus.in_data[c*BYTE_W +: BYTE_W];
        assign out_free = ~valid_q | bus.out_ready[c];
        assign ready    = ((cnt != LAST) | out_free) & ~flush_pend;
        assign accept   = bus.in_valid[c] & ready;
        assign complete = accept & (cnt == LAST);

        // Byte number cnt goes to lane BYTES_PER_WORD-1-cnt, so byte 0 sits at the MSBs.
        always_comb begin
            acc_ins = acc;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (cnt == CNT_W'(BYTES_PER_WORD - 1 - i))
                    acc_ins[i*BYTE_W +: BYTE_W] = din;
            end
        end

        assign acc_nxt = accept ? acc_ins : acc;
        assign cnt_nxt = accept ? cnt + CNT_W'(1) : cnt;

`ifdef BYTE_WORD_PACKER_FLUSH_EN
        assign flush_req = bus.flush[c] | flush_pend;
`else
        assign flush_req = 1'b0;
`endif
        // A same-cycle completing byte takes precedence; the flush then has nothing left to emit.
        assign fire = flush_req & ~complete & (cnt_nxt != '0) & out_free;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc        <= '0;
                cnt        <= '0;
                word_q     <= '0;
                bytes_q    <= '0;
                valid_q    <= 1'b0;
                flush_pend <= 1'b0;
            end else begin
                if (complete) begin
                    word_q  <= acc_ins;
                    bytes_q <= FULL;
                    valid_q <= 1'b1;
                    cnt     <= '0;
                    acc     <= '0;
                end else if (fire) begin
                    word_q  <= acc_nxt;
                    bytes_q <= cnt_nxt;
                    valid_q <= 1'b1;
                    cnt     <= '0;
                    acc     <= '0;
                end else begin
                    if (bus.out_ready[c])
                        valid_q <= 1'b0;
                    cnt <= cnt_nxt;
                    acc <= acc_nxt;
                end
                flush_pend <= flush_req & ~complete & ~fire & (cnt_nxt != '0);
            end
        end

        assign bus.in_ready[c]                   = ready;
        assign bus.out_valid[c]                  = valid_q;
        assign bus.out_data[c*WORD_W +: WORD_W]  = word_q;
        assign bus.out_bytes[c*CNT_W +: CNT_W]   = bytes_q;
    end
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: stimulus pushes expected words, a monitor pops on each drain.
module tb_byte_word_packer;
    localparam int CH  = 2;
    localparam int BW  = 8;
    localparam int BPW = 4;
    localparam int WW  = BW * BPW;
    localparam int CW  = $clog2(BPW + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [WW+CW-1:0] exp_q [CH][$];

    byte_word_packer_if #(.CHANNELS(CH), .BYTE_W(BW), .BYTES_PER_WORD(BPW)) bus ();

    byte_word_packer #(.CHANNELS(CH), .BYTE_W(BW), .BYTES_PER_WORD(BPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input int c, input logic [WW-1:0] w, input logic [CW-1:0] n);
        exp_q[c].push_back({w, n});
    endtask

    task automatic present(input int c, input logic [BW-1:0] b);
        bus.in_valid[c] = 1'b1;
        bus.in_data[c*BW +: BW] = b;
    endtask

    task automatic wait_accept(input int c);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready[c] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout lane %0d: in_ready stayed 0, expected 1", c);
        end
        @(posedge clk);
        #1;
        bus.in_valid[c] = 1'b0;
    endtask

    task automatic send(input int c, input logic [BW-1:0] b);
        present(c, b);
        wait_accept(c);
    endtask

    task automatic pulse_flush(input int c);
        bus.flush[c] = 1'b1;
        @(posedge clk);
        #1;
        bus.flush[c] = 1'b0;
    endtask

    // Monitor: every word handed over must match the oldest expectation for its lane.
    initial begin
        logic [WW+CW-1:0] e;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (rst_n && bus.out_valid[c] && bus.out_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word lane %0d: got %0h, expected none", c,
                                 bus.out_data[c*WW +: WW]);
                    end else begin
                        e = exp_q[c].pop_front();
                        check($sformatf("word_data lane %0d", c), 64'(bus.out_data[c*WW +: WW]), 64'(e[WW+CW-1:CW]));
                        check($sformatf("word_bytes lane %0d", c), 64'(bus.out_bytes[c*CW +: CW]), 64'(e[CW-1:0]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.flush     = '0;
        bus.out_ready = '1;
        #2;
        check("reset_in_ready", 64'(bus.in_ready), 64'h3);
        check("reset_out_valid", 64'(bus.out_valid), 64'h0);
        check("reset_out_data", 64'(bus.out_data), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word, then latency: valid visible right after the completing edge.
        expect_word(0, 32'h11223344, 3'd4);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        @(negedge clk);
        check("latency_out_valid", 64'(bus.out_valid[0]), 64'h1);
        @(posedge clk); #1;

        // Zero bytes are data.
        expect_word(0, 32'h00000000, 3'd4);
        for (int i = 0; i < 4; i++) send(0, 8'h00);
        repeat (2) @(posedge clk); #1;

        // Backpressure: second word stalls on its completing byte.
        bus.out_ready[0] = 1'b0;
        expect_word(0, 32'h01020304, 3'd4);
        expect_word(0, 32'h05060708, 3'd4);
        for (int i = 1; i <= 7; i++) send(0, 8'(i));
        present(0, 8'h08);
        @(negedge clk);
        check("stall_in_ready", 64'(bus.in_ready[0]), 64'h0);
        check("stall_held_valid", 64'(bus.out_valid[0]), 64'h1);
        check("stall_held_data", 64'(bus.out_data[31:0]), 64'h01020304);
        @(posedge clk); #1;
        bus.out_ready[0] = 1'b1;
        wait_accept(0);
        repeat (2) @(posedge clk); #1;

        // Flush of a partial word.
        send(0, 8'hAA); send(0, 8'hBB);
`ifdef BYTE_WORD_PACKER_FLUSH_EN
        expect_word(0, 32'hAABB0000, 3'd2);
        pulse_flush(0);
        repeat (2) @(posedge clk); #1;
        expect_word(0, 32'hCCDD0000, 3'd2);
        send(0, 8'hCC); send(0, 8'hDD);
        pulse_flush(0);
`else
        pulse_flush(0);
        repeat (2) @(posedge clk); #1;
        expect_word(0, 32'hAABBCCDD, 3'd4);
        send(0, 8'hCC); send(0, 8'hDD);
`endif
        repeat (3) @(posedge clk); #1;

        // Flush together with the completing byte yields exactly one full word.
        expect_word(0, 32'h55667788, 3'd4);
        send(0, 8'h55); send(0, 8'h66); send(0, 8'h77);
        present(0, 8'h88);
        bus.flush[0] = 1'b1;
        wait_accept(0);
        bus.flush[0] = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Two independent lanes, skewed by one cycle.
        expect_word(0, 32'h10111213, 3'd4);
        expect_word(1, 32'h20212223, 3'd4);
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i));
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) send(1, 8'(8'h20 + i));
            end
        join
        repeat (3) @(posedge clk); #1;

        // Reset mid-word with a held output: everything discarded.
        bus.out_ready = '0;
        send(0, 8'hB1); send(0, 8'hB2); send(0, 8'hB3); send(0, 8'hB4);
        send(0, 8'hA7); send(0, 8'hA8); send(0, 8'hA9);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(bus.out_valid), 64'h0);
        check("midreset_out_data", 64'(bus.out_data), 64'h0);
        check("midreset_out_bytes", 64'(bus.out_bytes), 64'h0);
        check("midreset_in_ready", 64'(bus.in_ready), 64'h3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = '1;
        expect_word(0, 32'hA1A2A3A4, 3'd4);
        send(0, 8'hA1); send(0, 8'hA2); send(0, 8'hA3); send(0, 8'hA4);
        repeat (5) @(posedge clk); #1;

        check("lane0_queue_drained", 64'(exp_q[0].size()), 64'h0);
        check("lane1_queue_drained", 64'(exp_q[1].size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Multi-channel, parametrised byte-to-word packer with valid/ready handshaking on both sides. Each channel collects `BYTES_PER_WORD` input bytes into one output word, first byte in the most significant lane. An explicit per-lane fill count replaces zero-as-empty detection, so zero bytes are legal data. The block sits between byte-serial receive paths and word-wide consumers, with one independent lane per source.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent lanes (≥1)
- `BYTE_W`, 8, input byte width (≥1)
- `BYTES_PER_WORD`, 4, bytes per output word (≥2); `WORD_W = BYTE_W*BYTES_PER_WORD`
- `CNT_W`, `$clog2(BYTES_PER_WORD+1)`, width of the byte-count field

Ports (lane c occupies slice `[c*W +: W]` of each vector):
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in CHANNELS: byte present per lane
- `in_data` in CHANNELS*BYTE_W: input bytes
- `in_ready` out CHANNELS: lane accepts a byte this cycle
- `flush` in CHANNELS: single-cycle request to emit a partial word
- `out_valid` out CHANNELS: word register holds a word
- `out_data` out CHANNELS*WORD_W: packed words
- `out_bytes` out CHANNELS*CNT_W: number of valid bytes in the word, MSB-aligned
- `out_ready` in CHANNELS: consumer takes the word

## Operation
- Per-lane state: accumulator (`WORD_W`), fill count `cnt` (0..BYTES_PER_WORD-1), output register with `out_valid`/`out_bytes`, and a `flush_pend` bit.
- Accept: `in_valid & in_ready` writes the byte into lane `BYTES_PER_WORD-1-cnt` of the accumulator, so byte 0 lands at the MSBs. `cnt` then increments.
- Complete: the byte accepted at `cnt==BYTES_PER_WORD-1` loads `{accumulator, byte}` into the output register. This sets `out_valid=1` and `out_bytes=BYTES_PER_WORD`, and clears `cnt` and the accumulator to 0.
- `in_ready = (cnt != BYTES_PER_WORD-1) | ~out_valid | out_ready`. This signal is combinational and per lane.
- Drain: `out_valid & out_ready` clears `out_valid`. If the same cycle also loads a new word, `out_valid` stays 1 and the new word replaces the old one.
- Byte values are never inspected. 0x00 is ordinary data.
- Lanes are fully independent. No arbitration is shared between lanes.
- Arithmetic: `cnt` wraps only through the complete/flush paths and never exceeds `BYTES_PER_WORD-1`. Unfilled lanes of a partial word read 0.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - `out_valid=0`, `out_data=0`, `out_bytes=0`.
  - `cnt=0`, accumulator=0, `flush_pend=0`.
  - `in_ready` reads all-ones while in reset and afterwards, until lanes fill.
- Reset mid-word discards the partial word and any held output.
- Latency: `out_valid` rises on the clock edge that accepts the final byte, i.e. it is visible the next cycle.
- Throughput: with `out_ready=1`, one byte per cycle per lane and one word every `BYTES_PER_WORD` cycles, with no bubbles.
- Backpressure: with `out_valid=1` and `out_ready=0`, the lane still accepts bytes up to `cnt==BYTES_PER_WORD-1`, then stalls with `in_ready=0` on the completing byte.
- Flush timing is defined under Configuration.

## Configuration
- Macro: `BYTE_WORD_PACKER_FLUSH_EN`.
- Defined — flush is captured into `flush_pend`. The pending flush fires in the first cycle where `cnt>0` and the output register is free (`~out_valid | out_ready`). It then:
  - loads the partial accumulator into the output register;
  - sets `out_bytes=cnt`;
  - clears `cnt` and the accumulator to 0;
  - clears `flush_pend`.
- Flush with `cnt==0` (after any same-cycle byte is counted) is a no-op and clears `flush_pend`.
- Flush and byte in the same cycle: the byte is included first.
  - If the byte completes the word, a full word is emitted with `out_bytes=BYTES_PER_WORD`, and no extra empty word follows.
- While `flush_pend=1`, `in_ready=0` for that lane.
- Not defined — `flush` is ignored and `flush_pend` is constant 0. `out_bytes` always equals `BYTES_PER_WORD` whenever `out_valid=1`.

## Test plan
- Defaults, `out_ready=1`, lane 0 bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> next cycle `out_data[31:0]=0x11223344`, `out_bytes=4`, `out_valid[0]=1` for exactly one cycle.
- Lane 0 bytes 0x00 ×4 -> one word 0x00000000 with `out_valid=1`, `out_bytes=4`.
- `out_ready=0`, lane 0 bytes 0x01..0x08 -> 0x01020304 held; `in_ready[0]=0` while 0x08 is presented. After `out_ready=1` for one cycle, 0x05060708 appears the next cycle with no byte lost.
- Macro on: bytes 0xAA,0xBB then `flush` -> word 0xAABB0000, `out_bytes=2`. Macro off: same stimulus gives no output, and the next two bytes 0xCC,0xDD complete 0xAABBCCDD.
- Lanes 0 and 1 fed 0x10..0x13 and 0x20..0x23 simultaneously, skewed by 1 cycle -> 0x10111213 and 0x20212223 each appear one cycle after their own last byte.
- `rst_n` pulsed low after 3 bytes -> all outputs 0 immediately. Then 0xA1..0xA4 yields exactly 0xA1A2A3A4.
